// File: rtl/hub75_panel_rx.sv
// hub75_panel_rx - receive-side model of a HUB75 LED panel shift chain.
//
// Oversamples the HUB75 bus on the local clock, rebuilds each latched
// row and streams it out one column word per valid/ready handshake.
//
// Parameters:
//   COLS : columns per shifted row (>= 2)
//   CW   : column index width (2**CW >= COLS)
//   ONW  : on-time counter width
//
// Ports:
//   clk, rst            local sample clock, async active-high reset
//   r0,g0,b0,r1,g1,b1   HUB75 colour data (asynchronous)
//   a[3:0]              HUB75 row address (asynchronous)
//   blank, sclk, latch  HUB75 control (asynchronous)
//   out_valid/out_ready pixel word handshake
//   out_row, out_col    row address captured at latch, column index
//   out_data            pixel bits {r1,g1,b1,r0,g0,b0}
//   row_done            one-cycle pulse after the last column is accepted
//   err_overrun         sticky: latch while the previous row was streaming
//   err_len             sticky: latch with shift count != COLS
//   err_clr             clears both sticky error flags
//   on_time             clk cycles blank was low in the previous latch interval
//
// Optional feature macro: HUB75_PANEL_RX_ONTIME_EN builds the on-time
// counter; without it on_time is tied to zero.

module hub75_panel_rx #(
   parameter int COLS = 192,
   parameter int CW   = 8,
   parameter int ONW  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          r0,
   input  logic          g0,
   input  logic          b0,
   input  logic          r1,
   input  logic          g1,
   input  logic          b1,
   input  logic [3:0]    a,
   input  logic          blank,
   input  logic          sclk,
   input  logic          latch,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [3:0]    out_row,
   output logic [CW-1:0] out_col,
   output logic [5:0]    out_data,
   output logic          row_done,
   output logic          err_overrun,
   output logic          err_len,
   input  logic          err_clr,
   output logic [ONW-1:0] on_time
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   localparam logic [CW:0]   CNT_ROW  = (CW+1)'(COLS);
   localparam logic [CW:0]   CNT_MAX  = (CW+1)'(COLS + 1);
   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

   // synchronisers
   logic [5:0] d_s1, d_s2;
   logic [3:0] a_s1, a_s2;
   logic       sclk_s1, sclk_s2, sclk_s3;
   logic       latch_s1, latch_s2, latch_s3;
   logic       blank_s1, blank_s2, blank_s3;

   // shift chain and streamer state
   logic [COLS-1:0][5:0] sreg, sreg_nxt;
   logic [COLS-1:0][5:0] hold;
   logic [CW:0]          scnt, scnt_nxt;
   logic [0:0]           state;

   logic sclk_rise, latch_rise;
   logic len_set, ovr_set;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_s1     <= '0;
         d_s2     <= '0;
         a_s1     <= '0;
         a_s2     <= '0;
         sclk_s1  <= 1'b0;
         sclk_s2  <= 1'b0;
         sclk_s3  <= 1'b0;
         latch_s1 <= 1'b0;
         latch_s2 <= 1'b0;
         latch_s3 <= 1'b0;
         blank_s1 <= 1'b1;
         blank_s2 <= 1'b1;
         blank_s3 <= 1'b1;
      end else begin
         d_s1     <= {r1, g1, b1, r0, g0, b0};
         d_s2     <= d_s1;
         a_s1     <= a;
         a_s2     <= a_s1;
         sclk_s1  <= sclk;
         sclk_s2  <= sclk_s1;
         sclk_s3  <= sclk_s2;
         latch_s1 <= latch;
         latch_s2 <= latch_s1;
         latch_s3 <= latch_s2;
         blank_s1 <= blank;
         blank_s2 <= blank_s1;
         blank_s3 <= blank_s2;
      end
   end

   // A shift in the latch cycle is applied first, so the latch sees the
   // post-shift register and count.
   always_comb begin
      sclk_rise  = sclk_s2 & ~sclk_s3;
      latch_rise = latch_s2 & ~latch_s3;
      sreg_nxt   = sreg;
      scnt_nxt   = scnt;
      if (sclk_rise) begin
         sreg_nxt = {d_s2, sreg[COLS-1:1]};
         if (scnt != CNT_MAX)
            scnt_nxt = scnt + 1'b1;
      end
      len_set = latch_rise && (scnt_nxt != CNT_ROW);
      ovr_set = latch_rise && (state == ST_STREAM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg <= '0;
         scnt <= '0;
      end else begin
         sreg <= sreg_nxt;
         scnt <= latch_rise ? '0 : scnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         hold     <= '0;
         out_row  <= '0;
         out_col  <= '0;
         row_done <= 1'b0;
      end else begin
         row_done <= 1'b0;
         if (state == ST_IDLE) begin
            if (latch_rise) begin
               hold    <= sreg_nxt;
               out_row <= a_s2;
               out_col <= '0;
               state   <= ST_STREAM;
            end
         end else if (out_ready) begin
            if (out_col == LAST_COL) begin
               out_col  <= '0;
               row_done <= 1'b1;
               state    <= ST_IDLE;
            end else begin
               out_col <= out_col + 1'b1;
            end
         end
      end
   end

   // hold is frozen while streaming, so the word stays stable under backpressure
   assign out_valid = (state == ST_STREAM);
   assign out_data  = out_valid ? hold[out_col] : '0;

   // a newly detected error wins over a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_len     <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         err_len     <= len_set | (err_len & ~err_clr);
         err_overrun <= ovr_set | (err_overrun & ~err_clr);
      end
   end

   // blank only matters as a level; its third stage has no consumer
   logic unused_blank;

`ifdef HUB75_PANEL_RX_ONTIME_EN
   logic [ONW-1:0] on_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         on_cnt  <= '0;
         on_time <= '0;
      end else if (latch_rise) begin
         on_time <= on_cnt;
         on_cnt  <= '0;
      end else if (!blank_s2 && (on_cnt != '1)) begin
         on_cnt <= on_cnt + 1'b1;
      end
   end

   assign unused_blank = blank_s3;
`else
   assign on_time      = '0;
   assign unused_blank = ^{blank_s2, blank_s3};
`endif

endmodule
